// File: rtl/flip_manager_pkg.sv
// Shared types and helpers for the flip manager's scheduling logic.
package flip_manager_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } flip_sched_state_e;

    // Largest positive two's-complement value representable in width bits (width <= 64).
    function automatic logic [63:0] energy_max_pos(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    localparam int unsigned ENERGY_TOTAL_BIT_DEF = 32;
    localparam logic [ENERGY_TOTAL_BIT_DEF-1:0] ENERGY_MAX_POS =
        ENERGY_TOTAL_BIT_DEF'(energy_max_pos(ENERGY_TOTAL_BIT_DEF));

endpackage

// File: rtl/flip_stall_tracker.sv
// Per-pass statistics: retired-energy count, consecutive push-none count and best energy.
module flip_stall_tracker
    import flip_manager_pkg::*;
#(
    parameter int unsigned ENERGY_TOTAL_BIT = 32,
    parameter int unsigned ITER_BIT         = 16,
    parameter int unsigned STALL_BIT        = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clr_i,
    input  logic                               energy_ev_i,
    input  logic                               push_none_i,
    input  logic signed [ENERGY_TOTAL_BIT-1:0] energy_i,
    output logic        [STALL_BIT-1:0]        stall_cnt_o,
    output logic        [ITER_BIT-1:0]         iter_cnt_o,
    output logic signed [ENERGY_TOTAL_BIT-1:0] best_energy_o
);

    localparam logic signed [ENERGY_TOTAL_BIT-1:0] BEST_INIT =
        ENERGY_TOTAL_BIT'(energy_max_pos(ENERGY_TOTAL_BIT));

    logic        [STALL_BIT-1:0]        stall_q, stall_d;
    logic        [ITER_BIT-1:0]         iter_q, iter_d;
    logic signed [ENERGY_TOTAL_BIT-1:0] best_q, best_d;

    // Saturating counters; accepted (non push-none) energies update the minimum.
    always_comb begin
        stall_d = stall_q;
        iter_d  = iter_q;
        best_d  = best_q;
        if (clr_i) begin
            stall_d = '0;
            iter_d  = '0;
            best_d  = BEST_INIT;
        end else if (energy_ev_i) begin
            if (iter_q != '1) iter_d = iter_q + ITER_BIT'(1);
            if (push_none_i) begin
                if (stall_q != '1) stall_d = stall_q + STALL_BIT'(1);
            end else begin
                stall_d = '0;
                if (energy_i < best_q) best_d = energy_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
            iter_q  <= '0;
            best_q  <= BEST_INIT;
        end else begin
            stall_q <= stall_d;
            iter_q  <= iter_d;
            best_q  <= best_d;
        end
    end

    assign stall_cnt_o   = stall_q;
    assign iter_cnt_o    = iter_q;
    assign best_energy_o = best_q;

endmodule

// File: rtl/flip_scheduler.sv
// Annealing-pass sequencer: flushes the maintainer, issues candidates with bounded
// in-flight depth, and ends the pass on iteration count or stagnation.
module flip_scheduler
    import flip_manager_pkg::*;
#(
    parameter int unsigned SPIN_DEPTH       = 2,
    parameter int unsigned ENERGY_TOTAL_BIT = 32,
    parameter int unsigned ITER_BIT         = 16,
    parameter int unsigned STALL_BIT        = 8,
    parameter int unsigned INFL_BIT         = $clog2(SPIN_DEPTH + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic        [ITER_BIT-1:0]         cfg_iter_num_i,
    input  logic        [STALL_BIT-1:0]        cfg_stall_limit_i,
    input  logic                               cfg_cmp_en_i,
    output logic                               maint_en_o,
    output logic                               maint_flush_o,
    output logic                               maint_en_comparison_o,
    output logic                               issue_valid_o,
    input  logic                               issue_ready_i,
    input  logic                               energy_valid_i,
    input  logic                               energy_ready_i,
    input  logic signed [ENERGY_TOTAL_BIT-1:0] energy_i,
    input  logic                               push_none_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic        [ITER_BIT-1:0]         iter_cnt_o,
    output logic        [INFL_BIT-1:0]         inflight_o,
    output logic signed [ENERGY_TOTAL_BIT-1:0] best_energy_o
);

    flip_sched_state_e     state_q, state_d;
    logic [ITER_BIT-1:0]   iter_num_q, iter_num_d;
    logic [STALL_BIT-1:0]  stall_lim_q, stall_lim_d;
    logic                  cmp_en_q, cmp_en_d;
    logic [ITER_BIT-1:0]   issued_q, issued_d;
    logic [INFL_BIT-1:0]   inflight_q, inflight_d;
    logic                  err_q, err_d;

    logic [STALL_BIT-1:0]  stall_cnt;
    logic                  start_c;
    logic                  stop_c;
    logic                  issue_ev_c;
    logic                  energy_ev_c;

    assign start_c     = (state_q == ST_IDLE) && start_i;
    assign energy_ev_c = energy_valid_i && energy_ready_i;
    assign issue_ev_c  = issue_valid_o && issue_ready_i;
    assign stop_c      = (issued_q == iter_num_q) ||
                         ((stall_lim_q != '0) && (stall_cnt >= stall_lim_q));

    // Next state and state-decoded outputs.
    always_comb begin
        state_d               = state_q;
        maint_en_o            = 1'b0;
        maint_flush_o         = 1'b0;
        issue_valid_o         = 1'b0;
        done_o                = 1'b0;
        busy_o                = (state_q != ST_IDLE);
        maint_en_comparison_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                maint_flush_o = 1'b1;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                maint_en_o            = 1'b1;
                maint_en_comparison_o = cmp_en_q && (iter_cnt_o != '0);
                issue_valid_o         = !stop_c && (issued_q < iter_num_q) &&
                                        (inflight_q < INFL_BIT'(SPIN_DEPTH));
                if (stop_c) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                maint_en_o            = 1'b1;
                maint_en_comparison_o = cmp_en_q && (iter_cnt_o != '0);
                if ((inflight_q == '0) && !energy_ev_c) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Config capture, issue count, in-flight tracking and sticky protocol error.
    always_comb begin
        iter_num_d  = iter_num_q;
        stall_lim_d = stall_lim_q;
        cmp_en_d    = cmp_en_q;
        issued_d    = issued_q;
        inflight_d  = inflight_q;
        err_d       = err_q;
        if (issue_ev_c) issued_d = issued_q + ITER_BIT'(1);
        case ({issue_ev_c, energy_ev_c})
            2'b10: inflight_d = inflight_q + INFL_BIT'(1);
            2'b01: begin
                if (inflight_q == '0) err_d = 1'b1;
                else                  inflight_d = inflight_q - INFL_BIT'(1);
            end
            default: inflight_d = inflight_q;
        endcase
        if (start_c) begin
            iter_num_d  = cfg_iter_num_i;
            stall_lim_d = cfg_stall_limit_i;
            cmp_en_d    = cfg_cmp_en_i;
            issued_d    = '0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            iter_num_q  <= '0;
            stall_lim_q <= '0;
            cmp_en_q    <= 1'b0;
            issued_q    <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_num_q  <= iter_num_d;
            stall_lim_q <= stall_lim_d;
            cmp_en_q    <= cmp_en_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

    flip_stall_tracker #(
        .ENERGY_TOTAL_BIT (ENERGY_TOTAL_BIT),
        .ITER_BIT         (ITER_BIT),
        .STALL_BIT        (STALL_BIT)
    ) u_tracker (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clr_i         (start_c),
        .energy_ev_i   (energy_ev_c),
        .push_none_i   (push_none_i),
        .energy_i      (energy_i),
        .stall_cnt_o   (stall_cnt),
        .iter_cnt_o    (iter_cnt_o),
        .best_energy_o (best_energy_o)
    );

    assign err_o      = err_q;
    assign inflight_o = inflight_q;

endmodule

// File: tb/tb_flip_scheduler.sv
// Directed bench for flip_scheduler with a fixed-latency spin/energy responder.
module tb_flip_scheduler;

    logic               clk;
    logic               rst_i;
    logic               start_i;
    logic [15:0]        cfg_iter_num_i;
    logic [7:0]         cfg_stall_limit_i;
    logic               cfg_cmp_en_i;
    logic               maint_en_o;
    logic               maint_flush_o;
    logic               maint_en_comparison_o;
    logic               issue_valid_o;
    logic               issue_ready_i;
    logic               energy_valid_i;
    logic               energy_ready_i;
    logic signed [31:0] energy_i;
    logic               push_none_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [15:0]        iter_cnt_o;
    logic [1:0]         inflight_o;
    logic signed [31:0] best_energy_o;

    // Responder state (owned by the responder process) and manual overrides.
    logic               resp_en;
    logic               r_valid, r_pn, m_valid, m_pn;
    logic signed [31:0] r_energy, m_energy;
    logic signed [31:0] e_tab [16];
    logic               pn_tab [16];
    logic               cmp_log [16];
    int                 due_q [$];
    int                 cyc, ridx, issues_seen, done_seen, peak_inf;

    int nvec;
    int nfail;

    assign energy_valid_i = resp_en ? r_valid  : m_valid;
    assign energy_i       = resp_en ? r_energy : m_energy;
    assign push_none_i    = resp_en ? r_pn     : m_pn;

    flip_scheduler dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .cfg_iter_num_i        (cfg_iter_num_i),
        .cfg_stall_limit_i     (cfg_stall_limit_i),
        .cfg_cmp_en_i          (cfg_cmp_en_i),
        .maint_en_o            (maint_en_o),
        .maint_flush_o         (maint_flush_o),
        .maint_en_comparison_o (maint_en_comparison_o),
        .issue_valid_o         (issue_valid_o),
        .issue_ready_i         (issue_ready_i),
        .energy_valid_i        (energy_valid_i),
        .energy_ready_i        (energy_ready_i),
        .energy_i              (energy_i),
        .push_none_i           (push_none_i),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .err_o                 (err_o),
        .iter_cnt_o            (iter_cnt_o),
        .inflight_o            (inflight_o),
        .best_energy_o         (best_energy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Spin generator model: each accepted issue returns one energy 3 cycles later.
    initial begin
        cyc = 0; ridx = 0; issues_seen = 0; done_seen = 0; peak_inf = 0;
        r_valid = 1'b0; r_pn = 1'b0; r_energy = '0;
        forever begin
            @(negedge clk);
            cyc++;
            r_valid = 1'b0;
            if (rst_i) begin
                due_q.delete();
            end else begin
                if (maint_flush_o) begin
                    ridx = 0; issues_seen = 0; done_seen = 0; peak_inf = 0;
                    due_q.delete();
                end
                if (resp_en && due_q.size() > 0 && due_q[0] == cyc && ridx < 16) begin
                    r_valid      = 1'b1;
                    r_energy     = e_tab[ridx];
                    r_pn         = pn_tab[ridx];
                    cmp_log[ridx] = maint_en_comparison_o;
                    ridx++;
                    void'(due_q.pop_front());
                end
                if (resp_en && issue_valid_o && issue_ready_i) begin
                    issues_seen++;
                    due_q.push_back(cyc + 3);
                end
                if (done_o) done_seen++;
                if (int'(inflight_o) > peak_inf) peak_inf = int'(inflight_o);
            end
        end
    end

    task automatic start_pass(input logic [15:0] iters, input logic [7:0] lim, input logic cmp);
        @(negedge clk);
        cfg_iter_num_i    = iters;
        cfg_stall_limit_i = lim;
        cfg_cmp_en_i      = cmp;
        start_i           = 1'b1;
        @(negedge clk);
        start_i           = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_o) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_tab(input logic signed [31:0] e0, e1, e2, e3, e4,
                            input logic p1, p2, p3);
        for (int i = 0; i < 16; i++) begin
            e_tab[i] = 32'sd0; pn_tab[i] = 1'b0; cmp_log[i] = 1'bx;
        end
        e_tab[0] = e0; e_tab[1] = e1; e_tab[2] = e2; e_tab[3] = e3; e_tab[4] = e4;
        pn_tab[1] = p1; pn_tab[2] = p2; pn_tab[3] = p3;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nvec++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            nfail++; $display("FAIL reset_flags busy=%b done=%b err=%b want 0", busy_o, done_o, err_o); end
        nvec++; if (maint_en_o !== 1'b0 || maint_flush_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            nfail++; $display("FAIL reset_maint en=%b flush=%b issue=%b want 0", maint_en_o, maint_flush_o, issue_valid_o); end
        nvec++; if (best_energy_o !== 32'sh7FFFFFFF) begin
            nfail++; $display("FAIL reset_best got=%h want 7fffffff", best_energy_o); end
        nvec++; if (iter_cnt_o !== 16'd0 || inflight_o !== 2'd0) begin
            nfail++; $display("FAIL reset_cnt iter=%0d infl=%0d want 0", iter_cnt_o, inflight_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_basic_pass();
        bit ok;
        load_tab(100, 50, 70, 60, 0, 0, 0, 0);
        resp_en = 1'b1; issue_ready_i = 1'b1;
        start_pass(16'd4, 8'd0, 1'b0);
        nvec++; if (maint_flush_o !== 1'b1 || maint_en_o !== 1'b0 || issue_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            nfail++; $display("FAIL basic_flush flush=%b en=%b issue=%b busy=%b want 1/0/0/1", maint_flush_o, maint_en_o, issue_valid_o, busy_o); end
        @(negedge clk);
        nvec++; if (issue_valid_o !== 1'b1 || maint_en_o !== 1'b1) begin
            nfail++; $display("FAIL basic_first_issue issue=%b en=%b want 1/1", issue_valid_o, maint_en_o); end
        wait_done(ok);
        nvec++; if (!ok) begin nfail++; $display("FAIL basic_done_timeout got=0 want=1"); end
        nvec++; if (iter_cnt_o !== 16'd4 || best_energy_o !== 32'sd50 || busy_o !== 1'b1) begin
            nfail++; $display("FAIL basic_stats iter=%0d best=%0d busy=%b want 4/50/1", iter_cnt_o, best_energy_o, busy_o); end
        @(negedge clk);
        nvec++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            nfail++; $display("FAIL basic_idle busy=%b done=%b want 0/0", busy_o, done_o); end
        repeat (2) @(negedge clk);
        nvec++; if (peak_inf !== 2 || done_seen !== 1 || cmp_log[1] !== 1'b0) begin
            nfail++; $display("FAIL basic_peak peak=%0d dones=%0d cmp=%b want 2/1/0", peak_inf, done_seen, cmp_log[1]); end
    endtask

    task automatic test_signed_min();
        bit ok;
        load_tab(-5, 10, -20, 7, 0, 0, 0, 0);
        start_pass(16'd4, 8'd0, 1'b1);
        wait_done(ok);
        nvec++; if (!ok) begin nfail++; $display("FAIL min_done_timeout got=0 want=1"); end
        nvec++; if (best_energy_o !== -32'sd20) begin
            nfail++; $display("FAIL min_best got=%0d want -20", best_energy_o); end
        nvec++; if (cmp_log[0] !== 1'b0 || cmp_log[1] !== 1'b1 || cmp_log[2] !== 1'b1 || cmp_log[3] !== 1'b1) begin
            nfail++; $display("FAIL min_cmp got=%b%b%b%b want 0111", cmp_log[0], cmp_log[1], cmp_log[2], cmp_log[3]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        bit ok;
        load_tab(40, 30, 20, 10, 5, 1, 1, 1);
        start_pass(16'd10, 8'd3, 1'b0);
        wait_done(ok);
        nvec++; if (!ok) begin nfail++; $display("FAIL stall_done_timeout got=0 want=1"); end
        nvec++; if (iter_cnt_o !== 16'd5 || issues_seen !== 5) begin
            nfail++; $display("FAIL stall_count iter=%0d issued=%0d want 5/5", iter_cnt_o, issues_seen); end
        nvec++; if (best_energy_o !== 32'sd5) begin
            nfail++; $display("FAIL stall_best got=%0d want 5", best_energy_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        resp_en = 1'b0; issue_ready_i = 1'b0; m_valid = 1'b0; m_pn = 1'b0; m_energy = 32'sd3;
        start_pass(16'd3, 8'd0, 1'b0);
        @(negedge clk);
        nvec++; if (issue_valid_o !== 1'b1) begin
            nfail++; $display("FAIL b2b_issue got=%b want 1", issue_valid_o); end
        issue_ready_i = 1'b1;
        @(negedge clk);
        nvec++; if (inflight_o !== 2'd1) begin
            nfail++; $display("FAIL b2b_infl1 got=%0d want 1", inflight_o); end
        m_valid = 1'b1;
        @(negedge clk);
        nvec++; if (inflight_o !== 2'd1 || err_o !== 1'b0) begin
            nfail++; $display("FAIL b2b_same_cycle infl=%0d err=%b want 1/0", inflight_o, err_o); end
        issue_ready_i = 1'b0;
        @(negedge clk);
        nvec++; if (inflight_o !== 2'd0 || err_o !== 1'b0) begin
            nfail++; $display("FAIL b2b_drain infl=%0d err=%b want 0/0", inflight_o, err_o); end
        @(negedge clk);
        nvec++; if (inflight_o !== 2'd0 || err_o !== 1'b1) begin
            nfail++; $display("FAIL b2b_err infl=%0d err=%b want 0/1", inflight_o, err_o); end
        m_valid = 1'b0; issue_ready_i = 1'b1;
        @(negedge clk);
        issue_ready_i = 1'b0; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        wait_done(ok);
        nvec++; if (!ok || err_o !== 1'b1) begin
            nfail++; $display("FAIL b2b_end done=%b err=%b want 1/1", ok, err_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_iter();
        resp_en = 1'b1; issue_ready_i = 1'b1;
        start_pass(16'd0, 8'd0, 1'b0);
        nvec++; if (maint_flush_o !== 1'b1 || maint_en_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            nfail++; $display("FAIL zero_flush flush=%b en=%b issue=%b want 1/0/0", maint_flush_o, maint_en_o, issue_valid_o); end
        @(negedge clk);
        nvec++; if (maint_en_o !== 1'b1 || issue_valid_o !== 1'b0 || done_o !== 1'b0) begin
            nfail++; $display("FAIL zero_run en=%b issue=%b done=%b want 1/0/0", maint_en_o, issue_valid_o, done_o); end
        @(negedge clk);
        nvec++; if (maint_en_o !== 1'b1 || issue_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            nfail++; $display("FAIL zero_drain en=%b issue=%b done=%b busy=%b want 1/0/0/1", maint_en_o, issue_valid_o, done_o, busy_o); end
        @(negedge clk);
        nvec++; if (done_o !== 1'b1 || maint_en_o !== 1'b0) begin
            nfail++; $display("FAIL zero_done done=%b en=%b want 1/0", done_o, maint_en_o); end
        @(negedge clk);
        nvec++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            nfail++; $display("FAIL zero_idle busy=%b done=%b want 0/0", busy_o, done_o); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        load_tab(1, 2, 3, 4, 5, 0, 0, 0);
        resp_en = 1'b1; issue_ready_i = 1'b1;
        start_pass(16'd8, 8'd0, 1'b0);
        repeat (7) @(negedge clk);
        nvec++; if (inflight_o !== 2'd2 || iter_cnt_o !== 16'd2 || best_energy_o !== 32'sd1) begin
            nfail++; $display("FAIL mid_pre infl=%0d iter=%0d best=%0d want 2/2/1", inflight_o, iter_cnt_o, best_energy_o); end
        #2 rst_i = 1'b1;
        #1;
        nvec++; if (inflight_o !== 2'd0 || iter_cnt_o !== 16'd0 || best_energy_o !== 32'sh7FFFFFFF) begin
            nfail++; $display("FAIL mid_async infl=%0d iter=%0d best=%h want 0/0/7fffffff", inflight_o, iter_cnt_o, best_energy_o); end
        nvec++; if (busy_o !== 1'b0 || maint_en_o !== 1'b0 || issue_valid_o !== 1'b0 || err_o !== 1'b0) begin
            nfail++; $display("FAIL mid_async_ctl busy=%b en=%b issue=%b err=%b want 0", busy_o, maint_en_o, issue_valid_o, err_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if (done_o !== 1'b0) begin
                nfail++; $display("FAIL mid_no_done cycle=%0d got=%b want 0", i, done_o); end
        end
        rst_i = 1'b0;
        load_tab(9, 8, 7, 6, 0, 0, 0, 0);
        start_pass(16'd4, 8'd0, 1'b0);
        wait_done(ok);
        nvec++; if (!ok || iter_cnt_o !== 16'd4 || best_energy_o !== 32'sd6) begin
            nfail++; $display("FAIL mid_rerun done=%b iter=%0d best=%0d want 1/4/6", ok, iter_cnt_o, best_energy_o); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        nvec = 0; nfail = 0;
        rst_i = 1'b1; start_i = 1'b0;
        cfg_iter_num_i = '0; cfg_stall_limit_i = '0; cfg_cmp_en_i = 1'b0;
        issue_ready_i = 1'b0; energy_ready_i = 1'b1;
        resp_en = 1'b1; m_valid = 1'b0; m_pn = 1'b0; m_energy = '0;
        load_tab(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_pass();
        test_signed_min();
        test_stall();
        test_back_to_back();
        test_zero_iter();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
